// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, fetches over a req/ready port, issues one word at a time,
// applies branch/jump redirects on consume, counts retirements and flags fetch timeouts.
module fetch_sequencer #(
  parameter int unsigned           ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              branch_trig,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_adr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_adr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       retired_cnt,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam int unsigned       CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_retired;
  logic [CNT_W-1:0]  r_wait;
  logic              r_req;
  logic              r_valid;
  logic              r_busy;
  logic              r_err;

  logic              w_timeout;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_timeout = (TIMEOUT != 0) && (r_wait == LAST_WAIT);

  // Branch outranks jump when both are asserted on the consuming cycle.
  assign w_next_pc = branch_trig ? (r_pc + ADDR_W'(1) + branch_off) :
                     jump        ? jump_adr :
                                   (r_pc + ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
      r_wait    <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en && !r_err) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_wait  <= '0;
          end
        end
        S_FETCH: begin
          // A word arriving on the last allowed cycle still counts as a hit.
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= S_ISSUE;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            r_retired <= r_retired + 32'd1;
            r_pc      <= w_next_pc;
            r_valid   <= 1'b0;
            if (en) begin
              r_state <= S_FETCH;
              r_req   <= 1'b1;
              r_wait  <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_adr    = r_pc;
  assign pc_out      = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign retired_cnt = r_retired;
  assign busy        = r_busy;
  assign err         = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table plus hand-written
// sequences for timeout, sticky error and reset during a fetch.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, stall, branch_trig, jump, imem_ready;
  logic [31:0] branch_off, jump_adr, imem_rdata;
  logic        imem_req, instr_valid, busy, err;
  logic [31:0] imem_adr, instr, pc_out, retired_cnt;

  int n_vec = 0;
  int n_bad = 0;

  fetch_sequencer #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stall      (stall),
    .branch_trig(branch_trig),
    .branch_off (branch_off),
    .jump       (jump),
    .jump_adr   (jump_adr),
    .imem_req   (imem_req),
    .imem_adr   (imem_adr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .retired_cnt(retired_cnt),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en, stall, ready;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [31:0] jadr;
    logic        req;
    logic [31:0] adr;
    logic        valid;
    logic [31:0] ins;
    logic [31:0] ret;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string name, logic e, logic s, logic r, logic [31:0] rd,
                               logic b, logic [31:0] o, logic j, logic [31:0] ja,
                               logic q, logic [31:0] a, logic v, logic [31:0] i,
                               logic [31:0] rt, logic bz);
    vec_t t;
    t.name = name; t.en = e; t.stall = s; t.ready = r; t.rdata = rd;
    t.br = b; t.off = o; t.jmp = j; t.jadr = ja;
    t.req = q; t.adr = a; t.valid = v; t.ins = i; t.ret = rt; t.bsy = bz;
    return t;
  endfunction

  // Drive inputs, advance one clock, and leave time 1 unit past the edge for sampling.
  task automatic step(input logic e, input logic s, input logic r, input logic [31:0] rd,
                      input logic b, input logic [31:0] o, input logic j, input logic [31:0] ja);
    en = e; stall = s; imem_ready = r; imem_rdata = rd;
    branch_trig = b; branch_off = o; jump = j; jump_adr = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic q, input logic [31:0] a, input logic v,
                     input logic [31:0] i, input logic [31:0] rt, input logic bz, input logic er);
    n_vec++;
    if (imem_req !== q || imem_adr !== a || pc_out !== a || instr_valid !== v ||
        instr !== i || retired_cnt !== rt || busy !== bz || err !== er) begin
      n_bad++;
      $display("FAIL %s: got req=%b adr=%h pc=%h valid=%b instr=%h ret=%0d busy=%b err=%b, expected req=%b adr=%h valid=%b instr=%h ret=%0d busy=%b err=%b",
               name, imem_req, imem_adr, pc_out, instr_valid, instr, retired_cnt, busy, err,
               q, a, v, i, rt, bz, er);
    end else begin
      $display("vec %0d %s ok: adr=%h valid=%b ret=%0d", n_vec, name, imem_adr, instr_valid, retired_cnt);
    end
  endtask

  localparam logic [31:0] M3 = 32'hFFFF_FFFD;

  initial begin
    vecs.push_back(mkv("idle_to_fetch",     1,0,1,32'hA000_0000, 0,0,0,0,  1,32'h0,0,32'h0,0,1));
    vecs.push_back(mkv("fetch_pc0",         1,0,1,32'hA000_0000, 0,0,0,0,  0,32'h0,1,32'hA000_0000,0,1));
    vecs.push_back(mkv("consume_pc0",       1,0,0,0,             0,0,0,0,  1,32'h1,0,32'hA000_0000,1,1));
    vecs.push_back(mkv("fetch_pc1",         1,0,1,32'hA000_0001, 0,0,0,0,  0,32'h1,1,32'hA000_0001,1,1));
    vecs.push_back(mkv("consume_pc1",       1,0,0,0,             0,0,0,0,  1,32'h2,0,32'hA000_0001,2,1));
    vecs.push_back(mkv("fetch_pc2",         1,0,1,32'hA000_0002, 0,0,0,0,  0,32'h2,1,32'hA000_0002,2,1));
    vecs.push_back(mkv("consume_pc2",       1,0,0,0,             0,0,0,0,  1,32'h3,0,32'hA000_0002,3,1));
    vecs.push_back(mkv("fetch_pc3",         1,0,1,32'hA000_0003, 0,0,0,0,  0,32'h3,1,32'hA000_0003,3,1));
    vecs.push_back(mkv("jump_to_5",         1,0,0,0,             0,0,1,32'h5,  1,32'h5,0,32'hA000_0003,4,1));
    vecs.push_back(mkv("fetch_pc5",         1,0,1,32'hB000_0005, 0,0,0,0,  0,32'h5,1,32'hB000_0005,4,1));
    vecs.push_back(mkv("branch_minus3",     1,0,0,0,             1,M3,0,0, 1,32'h3,0,32'hB000_0005,5,1));
    vecs.push_back(mkv("fetch_ignores_jmp", 1,0,1,32'hC000_0003, 0,0,1,32'h99, 0,32'h3,1,32'hC000_0003,5,1));
    vecs.push_back(mkv("jump_to_5_again",   1,0,0,0,             0,0,1,32'h5,  1,32'h5,0,32'hC000_0003,6,1));
    vecs.push_back(mkv("fetch_ignores_br",  1,0,1,32'hC000_0005, 1,32'h7,0,0,  0,32'h5,1,32'hC000_0005,6,1));
    vecs.push_back(mkv("branch_beats_jump", 1,0,0,0,             1,M3,1,32'h40, 1,32'h3,0,32'hC000_0005,7,1));
    vecs.push_back(mkv("fetch_pc3_b",       1,0,1,32'hD000_0003, 0,0,0,0,  0,32'h3,1,32'hD000_0003,7,1));
    vecs.push_back(mkv("jump_to_8",         1,0,0,0,             0,0,1,32'h8,  1,32'h8,0,32'hD000_0003,8,1));
    vecs.push_back(mkv("fetch_pc8",         1,0,1,32'hD000_0008, 0,0,0,0,  0,32'h8,1,32'hD000_0008,8,1));
    vecs.push_back(mkv("stall_1",           1,1,0,0,             0,0,1,32'h40, 0,32'h8,1,32'hD000_0008,8,1));
    vecs.push_back(mkv("stall_2_br_ignored",1,1,0,0,             1,32'h5,1,32'h40, 0,32'h8,1,32'hD000_0008,8,1));
    vecs.push_back(mkv("stall_3",           1,1,0,0,             0,0,1,32'h40, 0,32'h8,1,32'hD000_0008,8,1));
    vecs.push_back(mkv("consume_jump_40",   1,0,0,0,             0,0,1,32'h40, 1,32'h40,0,32'hD000_0008,9,1));
    vecs.push_back(mkv("fetch_pc40",        1,0,1,32'hE000_0040, 0,0,0,0,  0,32'h40,1,32'hE000_0040,9,1));
    vecs.push_back(mkv("jump_to_max",       1,0,0,0,             0,0,1,32'hFFFF_FFFF, 1,32'hFFFF_FFFF,0,32'hE000_0040,10,1));
    vecs.push_back(mkv("fetch_max",         1,0,1,32'hE000_00FF, 0,0,0,0,  0,32'hFFFF_FFFF,1,32'hE000_00FF,10,1));
    vecs.push_back(mkv("pc_wraps_to_0",     1,0,0,0,             0,0,0,0,  1,32'h0,0,32'hE000_00FF,11,1));
    vecs.push_back(mkv("en_low_mid_fetch",  0,0,0,0,             0,0,0,0,  1,32'h0,0,32'hE000_00FF,11,1));
    vecs.push_back(mkv("fetch_completes",   0,0,1,32'hF000_0000, 0,0,0,0,  0,32'h0,1,32'hF000_0000,11,1));
    vecs.push_back(mkv("consume_to_idle",   0,0,0,0,             0,0,0,0,  0,32'h1,0,32'hF000_0000,12,0));
    vecs.push_back(mkv("idle_hold",         0,0,1,0,             0,0,0,0,  0,32'h1,0,32'hF000_0000,12,0));
    vecs.push_back(mkv("restart",           1,0,0,0,             0,0,0,0,  1,32'h1,0,32'hF000_0000,12,1));

    rst = 1'b1;
    step(0,0,0,0,0,0,0,0);
    step(1,0,1,32'hDEAD_BEEF,1,5,1,32'h77);
    chk("reset_state", 0, 32'h0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].en, vecs[k].stall, vecs[k].ready, vecs[k].rdata,
           vecs[k].br, vecs[k].off, vecs[k].jmp, vecs[k].jadr);
      chk(vecs[k].name, vecs[k].req, vecs[k].adr, vecs[k].valid, vecs[k].ins, vecs[k].ret, vecs[k].bsy, 1'b0);
    end

    // FETCH entered at pc=1 with counter 0; 15 more missed cycles keep waiting, the 16th times out.
    for (int c = 1; c <= 15; c++) begin
      step(1,0,0,0,0,0,0,0);
      chk($sformatf("waiting_%0d", c), 1, 32'h1, 0, 32'hF000_0000, 12, 1, 0);
    end
    step(1,0,0,0,0,0,0,0);
    chk("timeout_err", 0, 32'h1, 0, 32'hF000_0000, 12, 0, 1);
    for (int c = 0; c < 4; c++) begin
      step(1,0,1,32'h1234_5678,0,0,0,0);
      chk($sformatf("err_holds_idle_%0d", c), 0, 32'h1, 0, 32'hF000_0000, 12, 0, 1);
    end

    rst = 1'b1;
    step(1,0,0,0,0,0,0,0);
    chk("rst_clears_err", 0, 32'h0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;

    step(1,0,1,32'h1111_0000,0,0,0,0);
    chk("r2_fetch", 1, 32'h0, 0, 32'h0, 0, 1, 0);
    step(1,0,1,32'h1111_0000,0,0,0,0);
    chk("r2_issue", 0, 32'h0, 1, 32'h1111_0000, 0, 1, 0);
    step(1,0,0,0,0,0,1,32'h20);
    chk("r2_jump_20", 1, 32'h20, 0, 32'h1111_0000, 1, 1, 0);
    step(1,0,0,0,0,0,0,0);
    chk("r2_wait_20", 1, 32'h20, 0, 32'h1111_0000, 1, 1, 0);
    rst = 1'b1;
    step(1,0,1,32'h2222_0000,0,0,0,0);
    chk("rst_mid_fetch", 0, 32'h0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
